// File: rtl/ram16_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM16 pins.
// The arbiter connects through the slave modport; the master modport is the requesters/RAM side.
interface ram16_arbiter_if #(
  parameter int AW = 2,
  parameter int DW = 4
);
  logic          req0;
  logic          wr0;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0;
  logic          ack0;
  logic [DW-1:0] q0;

  logic          req1;
  logic          wr1;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1;
  logic          ack1;
  logic [DW-1:0] q1;

  logic          busy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  modport slave (
    input  req0, wr0, a0, d0, req1, wr1, a1, d1, ram_q,
    output ack0, q0, ack1, q1, busy, ram_en, ram_we, ram_a, ram_d
  );

  modport master (
    output req0, wr0, a0, d0, req1, wr1, a1, d1, ram_q,
    input  ack0, q0, ack1, q1, busy, ram_en, ram_we, ram_a, ram_d
  );
endinterface

// File: rtl/ram16_arbiter.sv
// Round-robin two-port access controller for a single RAM16: clears the RAM after reset,
// then serves one single-word read or write per three-cycle transaction.
module ram16_arbiter #(
  parameter int            AW       = 2,
  parameter int            DW       = 4,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  ram16_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          ptr;
  logic          win;
  logic          lat_wr;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_d;
  logic [DW-1:0] q0_r;
  logic [DW-1:0] q1_r;
  logic          grant;
  logic          grant_port;

  // Under contention the port that was not granted last wins.
  assign grant      = bus.req0 | bus.req1;
  assign grant_port = (bus.req0 & bus.req1) ? ~ptr : bus.req1;

  always_ff @(posedge clk) begin
    if (!rstn) state <= INIT;
    else       state <= state_nxt;
  end

  // NOTE: every output and next-state signal gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    bus.ram_en = 1'b0;
    bus.ram_we = 1'b0;
    bus.ram_a  = '0;
    bus.ram_d  = '0;
    bus.busy   = 1'b0;
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    if (!rstn) begin
      // Held in reset the RAM pins stay quiet and a pending ACK is dropped.
      bus.busy = 1'b1;
    end else begin
      case (state)
        INIT: begin
          bus.ram_en = 1'b1;
          bus.ram_we = 1'b1;
          bus.ram_a  = cnt;
          bus.ram_d  = INIT_VAL;
          bus.busy   = 1'b1;
          if (cnt == LAST_ADDR) state_nxt = IDLE;
        end
        IDLE: begin
          if (grant) state_nxt = ACCESS;
        end
        ACCESS: begin
          bus.ram_en = 1'b1;
          bus.ram_we = lat_wr;
          bus.ram_a  = lat_a;
          bus.ram_d  = lat_d;
          state_nxt  = RESP;
        end
        RESP: begin
          bus.ack0  = ~win;
          bus.ack1  = win;
          state_nxt = IDLE;
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      ptr    <= 1'b0;
      win    <= 1'b0;
      lat_wr <= 1'b0;
      lat_a  <= '0;
      lat_d  <= '0;
      q0_r   <= '0;
      q1_r   <= '0;
    end else begin
      if (state == INIT) cnt <= cnt + 1'b1;
      if (state == IDLE && grant) begin
        win    <= grant_port;
        ptr    <= grant_port;
        lat_wr <= grant_port ? bus.wr1 : bus.wr0;
        lat_a  <= grant_port ? bus.a1  : bus.a0;
        lat_d  <= grant_port ? bus.d1  : bus.d0;
      end
      if (state == ACCESS && !lat_wr) begin
        if (win) q1_r <= bus.ram_q;
        else     q0_r <= bus.ram_q;
      end
    end
  end

  assign bus.q0 = q0_r;
  assign bus.q1 = q1_r;

endmodule

// File: tb/tb_ram16_arbiter.sv
// Bench for ram16_arbiter: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations for sweep, latency, arbitration order and reset abort.
module tb_ram16_arbiter;

  localparam int            AW       = 2;
  localparam int            DW       = 4;
  localparam int            DEPTH    = 1 << AW;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ram16_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram16_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(INIT_VAL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // The RAM16 the arbiter drives: synchronous write, combinational read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.ram_en && bus.ram_we) ram[bus.ram_a] <= bus.ram_d;
  assign bus.ram_q = ram[bus.ram_a];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: clear sweep countdown, one transaction in flight, last grant.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q   [2];
  bit            m_valid = 1'b0;
  int            m_clear_left = 0;
  bit            m_txn = 1'b0;
  int            m_age = 0;
  bit            m_port, m_wr, m_last;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  always @(posedge clk) begin
    if (!rstn) begin
      m_valid      = 1'b1;
      m_clear_left = DEPTH;
      m_txn        = 1'b0;
      m_last       = 1'b0;
      m_q[0]       = '0;
      m_q[1]       = '0;
    end else if (m_valid) begin
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left] = INIT_VAL;
        m_clear_left--;
      end else if (m_txn && m_age == 0) begin
        if (m_wr) m_mem[m_a] = m_d;
        else      m_q[m_port] = m_mem[m_a];
        m_age = 1;
      end else if (m_txn) begin
        m_txn = 1'b0;
      end else if (bus.req0 || bus.req1) begin
        m_port = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_wr   = m_port ? bus.wr1 : bus.wr0;
        m_a    = m_port ? bus.a1  : bus.a0;
        m_d    = m_port ? bus.d1  : bus.d0;
        m_last = m_port;
        m_txn  = 1'b1;
        m_age  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic          e_en, e_we, e_busy, e_ack0, e_ack1;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      e_a = '0; e_d = '0;
      if (!rstn) begin
        e_busy = 1'b1;
      end else if (m_clear_left > 0) begin
        e_en = 1'b1; e_we = 1'b1; e_busy = 1'b1;
        e_a  = AW'(DEPTH - m_clear_left);
        e_d  = INIT_VAL;
      end else if (m_txn && m_age == 0) begin
        e_en = 1'b1; e_we = m_wr; e_a = m_a; e_d = m_d;
      end else if (m_txn) begin
        e_ack0 = !m_port;
        e_ack1 = m_port;
      end
      check("busy",   bus.busy,   e_busy);
      check("ram_en", bus.ram_en, e_en);
      check("ram_we", bus.ram_we, e_we);
      check("ack0",   bus.ack0,   e_ack0);
      check("ack1",   bus.ack1,   e_ack1);
      check("q0",     bus.q0,     m_q[0]);
      check("q1",     bus.q1,     m_q[1]);
      if (e_en) begin
        check("ram_a", bus.ram_a, e_a);
        check("ram_d", bus.ram_d, e_d);
      end
    end
  end

  // ACK log with cycle stamps for ordering and latency checks.
  int cyc = 0;
  int ack_port_q[$];
  int ack_cyc_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.ack0) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
    if (bus.ack1) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
  end

  // Returns just after the edge that ends the cycle carrying ACK number 'target'.
  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_port_q.size() < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ack_count", ack_port_q.size(), target);
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit port, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    int base, start;
    base  = ack_port_q.size();
    start = cyc;
    if (port) begin bus.req1 = 1'b1; bus.wr1 = wr; bus.a1 = a; bus.d1 = d; end
    else      begin bus.req0 = 1'b1; bus.wr0 = wr; bus.a0 = a; bus.d0 = d; end
    wait_acks(base + 1, 20);
    if (port) bus.req1 = 1'b0;
    else      bus.req0 = 1'b0;
    lat = -1;
    if (ack_port_q.size() > base) begin
      check("txn_ack_port", ack_port_q[base], port);
      lat = ack_cyc_q[base] - start + 1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lat, busy_cnt, base, start;
    int wr_addrs[$];
    int exp_order[4];

    rstn = 1'b0;
    bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.a0 = '0; bus.d0 = '0;
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.a1 = '0; bus.d1 = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Post-reset clear sweep: four writes of INIT_VAL to 0..3, BUSY for exactly four cycles.
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.ram_en && bus.ram_we) wr_addrs.push_back(int'(bus.ram_a));
    end
    @(posedge clk); #1;
    check("sweep_busy_cycles", busy_cnt, 4);
    check("sweep_write_count", wr_addrs.size(), 4);
    for (int i = 0; i < 4 && i < wr_addrs.size(); i++) check("sweep_addr", wr_addrs[i], i);

    // Port 0 write then read back.
    do_txn(1'b0, 1'b1, 2'd2, 4'd9, lat);
    check("p0_write_latency", lat, 3);
    do_txn(1'b0, 1'b0, 2'd2, 4'd0, lat);
    check("p0_read_latency", lat, 3);
    check("p0_read_q0", bus.q0, 4'd9);
    check("p0_read_q1_untouched", bus.q1, 4'd0);
    @(posedge clk); #1;

    // Port 1 alone, held: back-to-back reads every three cycles.
    base = ack_port_q.size();
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.a1 = 2'd2;
    wait_acks(base + 3, 30);
    if (ack_port_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) check("solo_p1_port", ack_port_q[base + i], 1);
      check("solo_p1_gap_a", ack_cyc_q[base + 1] - ack_cyc_q[base], 3);
      check("solo_p1_gap_b", ack_cyc_q[base + 2] - ack_cyc_q[base + 1], 3);
    end
    check("solo_p1_q1", bus.q1, 4'd9);

    // REQ0 joins while REQ1 stays high: port 0 next, then strict alternation.
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.a0 = 2'd1; bus.d0 = 4'd5;
    bus.a1 = 2'd1;
    wait_acks(base + 7, 40);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    exp_order = '{0, 1, 0, 1};
    if (ack_port_q.size() >= base + 7)
      for (int i = 0; i < 4; i++) check("contend_order", ack_port_q[base + 3 + i], exp_order[i]);
    check("contend_q1", bus.q1, 4'd5);
    @(posedge clk); #1;

    // Simultaneous rise; last grant was port 1, so port 0 goes first.
    base = ack_port_q.size();
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.a0 = 2'd1;
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.a1 = 2'd0; bus.d1 = 4'd3;
    wait_acks(base + 1, 20);
    bus.req0 = 1'b0;
    wait_acks(base + 2, 20);
    bus.req1 = 1'b0;
    if (ack_port_q.size() >= base + 2) begin
      check("simul_first", ack_port_q[base], 0);
      check("simul_second", ack_port_q[base + 1], 1);
    end
    check("simul_q0", bus.q0, 4'd5);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a port 1 write; a read queued during INIT follows.
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.a1 = 2'd3; bus.d1 = 4'd7;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.req1 = 1'b0;
    base  = ack_port_q.size();
    start = cyc;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.a0 = 2'd3;
    wait_acks(base + 1, 20);
    bus.req0 = 1'b0;
    if (ack_port_q.size() > base) begin
      check("abort_no_ack1", ack_port_q[base], 0);
      check("init_read_latency", ack_cyc_q[base] - start + 1, 7);
    end
    check("abort_read_q0", bus.q0, 4'd0);
    check("abort_q1_reset", bus.q1, 4'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
